// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer
// Command-side driver for the bit-slice ALU of the accumulator machine.
// Takes one opcode+operand per valid/ready transfer, drives the ALU operand,
// carry-in and ctrl lines from registers, then captures the result into the
// accumulator and the {N,Z,V,C} flag register.
// Z is derived locally from alu_out; the ALU's own zero output is not used.
//
// Build option: define ALU_SETTLE_EN to insert a WAIT state of SETTLE_CYCLES
// cycles between ISSUE and CAPTURE for slow ALU slices.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a command; LDA/CLR/illegal complete here
// ISSUE   | ALU inputs registered, ALU result propagating
// WAIT    | extra settle cycles (ALU_SETTLE_EN builds only)
// CAPTURE | latch alu_out into acc and update flags on leaving

module alu_op_sequencer #(
    parameter int N             = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [N-1:0] cmd_data,
    output logic [N-1:0] alu_in0,
    output logic [N-1:0] alu_in1,
    output logic         alu_c_in,
    output logic [2:0]   alu_ctrl,
    input  logic [N-1:0] alu_out,
    input  logic         alu_c_out,
    input  logic         alu_v,
    output logic [N-1:0] acc,
    output logic [3:0]   flags,
    output logic         done,
    output logic         illegal
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
        $error("SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [3:0] OP_LDA  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ORN  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_ANDN = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_CLR  = 4'd9;

    localparam logic [2:0] CTRL_ADD  = 3'b000;
    localparam logic [2:0] CTRL_SUB  = 3'b001;
    localparam logic [2:0] CTRL_OR   = 3'b010;
    localparam logic [2:0] CTRL_ORN  = 3'b011;
    localparam logic [2:0] CTRL_AND  = 3'b100;
    localparam logic [2:0] CTRL_ANDN = 3'b101;
    localparam logic [2:0] CTRL_NOT  = 3'b110;

`ifdef ALU_SETTLE_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_WAIT    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [3:0]     flags_q, flags_d;
    logic [N-1:0]   in1_q, in1_d;
    logic           cin_q, cin_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic           done_q, done_d;
    logic           illegal_q, illegal_d;
    logic           arith;
`ifdef ALU_SETTLE_EN
    logic [3:0]     cnt_q, cnt_d;
`endif

    // Sequencer registers; synchronous active-low reset abandons any command in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            flags_q   <= 4'b0000;
            in1_q     <= '0;
            cin_q     <= 1'b0;
            ctrl_q    <= 3'b000;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_SETTLE_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            in1_q     <= in1_d;
            cin_q     <= cin_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
`ifdef ALU_SETTLE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Only add and subtract produce meaningful carry/overflow; ctrl is stable until the next transfer
    assign arith = (ctrl_q == CTRL_ADD) || (ctrl_q == CTRL_SUB);

    // Next-state, command decode and result capture
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        flags_d   = flags_q;
        in1_d     = in1_q;
        cin_d     = cin_q;
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
`ifdef ALU_SETTLE_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LDA: begin
                            acc_d   = cmd_data;
                            flags_d = {cmd_data[N-1], (cmd_data == '0), 2'b00};
                            done_d  = 1'b1;
                        end
                        OP_CLR: begin
                            acc_d   = '0;
                            flags_d = 4'b0100;
                            done_d  = 1'b1;
                        end
                        OP_ADD, OP_ADC, OP_SUB, OP_OR, OP_ORN,
                        OP_AND, OP_ANDN, OP_NOT: begin
                            in1_d   = cmd_data;
                            cin_d   = 1'b0;
                            state_d = S_ISSUE;
                            case (cmd_op)
                                OP_ADD:  ctrl_d = CTRL_ADD;
                                OP_ADC: begin
                                    ctrl_d = CTRL_ADD;
                                    cin_d  = flags_q[0];
                                end
                                OP_SUB: begin
                                    ctrl_d = CTRL_SUB;
                                    cin_d  = 1'b1;
                                end
                                OP_OR:   ctrl_d = CTRL_OR;
                                OP_ORN:  ctrl_d = CTRL_ORN;
                                OP_AND:  ctrl_d = CTRL_AND;
                                OP_ANDN: ctrl_d = CTRL_ANDN;
                                default: ctrl_d = CTRL_NOT;
                            endcase
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
`ifdef ALU_SETTLE_EN
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = S_WAIT;
`else
                state_d = S_CAPTURE;
`endif
            end
`ifdef ALU_SETTLE_EN
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            S_CAPTURE: begin
                acc_d   = alu_out;
                flags_d = {alu_out[N-1], (alu_out == '0),
                           arith & alu_v, arith & alu_c_out};
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign alu_in0   = acc_q;
    assign alu_in1   = in1_q;
    assign alu_c_in  = cin_q;
    assign alu_ctrl  = ctrl_q;
    assign acc       = acc_q;
    assign flags     = flags_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule
